// File: rtl/vector_mul_seq_ctrl.sv
// Sequencing controller for a 32x32 signed multiply built from four 17x17 partial products
// issued in turn to one shared external multiplier, accumulated into a 64-bit result.
module vector_mul_seq_ctrl #(
    parameter int unsigned MUL_LAT = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_a_i,
    input  logic [31:0] in_b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_result_o,
    output logic        mul_en_o,
    output logic [16:0] mul_op1_o,
    output logic [16:0] mul_op2_o,
    input  logic [32:0] mul_res_i,
    output logic        busy_o
);

    localparam int unsigned TagDepth  = (MUL_LAT == 0) ? 1 : MUL_LAT;
    localparam logic [1:0]  DrainLast = (MUL_LAT == 0) ? 2'd0 : 2'(MUL_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;

    // Tag = {valid, slot}; travels alongside each issued partial product.
    logic [2:0]  tag_q [TagDepth];
    logic [2:0]  tag_d [TagDepth];
    logic [2:0]  issue_tag;
    logic [2:0]  tag_out;

    logic [16:0] a_lo, a_hi, b_lo, b_hi;
    logic [63:0] res_ext;
    logic [63:0] res_shifted;

    assign a_lo = {1'b0, a_q[15:0]};
    assign a_hi = {a_q[31], a_q[31:16]};
    assign b_lo = {1'b0, b_q[15:0]};
    assign b_hi = {b_q[31], b_q[31:16]};

    assign issue_tag = {mul_en_o, cnt_q};
    assign tag_out   = (MUL_LAT == 0) ? issue_tag : tag_q[TagDepth-1];

    assign res_ext = {{31{mul_res_i[32]}}, mul_res_i};

    always_comb begin
        res_shifted = res_ext;
        unique case (tag_out[1:0])
            2'd0:       res_shifted = res_ext;
            2'd1, 2'd2: res_shifted = res_ext << 16;
            2'd3:       res_shifted = res_ext << 32;
            default:    res_shifted = res_ext;
        endcase
    end

    always_comb begin
        tag_d[0] = issue_tag;
        for (int i = 1; i < TagDepth; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        mul_en_o    = 1'b0;

        // Tags only emerge while ISSUE/DRAIN is active, so this never races the clear below.
        if (tag_out[2]) begin
            acc_d = acc_q + res_shifted;
        end

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = in_a_i;
                    b_d     = in_b_i;
                    acc_d   = '0;
                    cnt_d   = 2'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mul_en_o = 1'b1;
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = (MUL_LAT == 0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == DrainLast) begin
                    cnt_d   = 2'd0;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Slot order LL, HL, LH, HH: bit 0 of the slot picks a's half, bit 1 picks b's half.
    assign mul_op1_o = mul_en_o ? (cnt_q[0] ? a_hi : a_lo) : 17'd0;
    assign mul_op2_o = mul_en_o ? (cnt_q[1] ? b_hi : b_lo) : 17'd0;

    assign busy_o       = (state_q != StIdle);
    assign out_result_o = acc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < TagDepth; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            for (int i = 0; i < TagDepth; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_vector_mul_seq_ctrl.sv
// Directed bench for vector_mul_seq_ctrl: one instance with a combinational multiplier,
// one with MUL_LAT=2 fed through a two-stage delayed multiplier model.
module tb_vector_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid0, in_valid2;
    logic [31:0] in_a, in_b;
    logic        out_ready;
    logic        sel;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        in_ready0, out_valid0, mul_en0, busy0;
    logic [63:0] result0;
    logic [16:0] op1_0, op2_0;
    logic [32:0] res0;

    logic        in_ready2, out_valid2, mul_en2, busy2;
    logic [63:0] result2;
    logic [16:0] op1_2, op2_2;
    logic [32:0] prod2, dly1, dly2;

    logic        s_in_ready, s_out_valid, s_mul_en, s_busy;
    logic [63:0] s_result;
    logic [16:0] s_op1, s_op2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared-multiplier models: 17x17 signed, 33-bit signed product.
    assign res0  = {{16{op1_0[16]}}, op1_0} * {{16{op2_0[16]}}, op2_0};
    assign prod2 = {{16{op1_2[16]}}, op1_2} * {{16{op2_2[16]}}, op2_2};
    always @(posedge clk) begin
        dly1 <= prod2;
        dly2 <= dly1;
    end

    assign s_in_ready  = sel ? in_ready2  : in_ready0;
    assign s_out_valid = sel ? out_valid2 : out_valid0;
    assign s_mul_en    = sel ? mul_en2    : mul_en0;
    assign s_busy      = sel ? busy2      : busy0;
    assign s_result    = sel ? result2    : result0;
    assign s_op1       = sel ? op1_2      : op1_0;
    assign s_op2       = sel ? op2_2      : op2_0;

    vector_mul_seq_ctrl #(.MUL_LAT(0)) u_dut0 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid0),
        .in_ready_o   (in_ready0),
        .in_a_i       (in_a),
        .in_b_i       (in_b),
        .out_valid_o  (out_valid0),
        .out_ready_i  (out_ready),
        .out_result_o (result0),
        .mul_en_o     (mul_en0),
        .mul_op1_o    (op1_0),
        .mul_op2_o    (op2_0),
        .mul_res_i    (res0),
        .busy_o       (busy0)
    );

    vector_mul_seq_ctrl #(.MUL_LAT(2)) u_dut2 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid2),
        .in_ready_o   (in_ready2),
        .in_a_i       (in_a),
        .in_b_i       (in_b),
        .out_valid_o  (out_valid2),
        .out_ready_i  (out_ready),
        .out_result_o (result2),
        .mul_en_o     (mul_en2),
        .mul_op1_o    (op1_2),
        .mul_op2_o    (op2_2),
        .mul_res_i    (dly2),
        .busy_o       (busy2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end
    endtask

    // One full operation with out_ready held high; called shortly after a rising edge in IDLE.
    task automatic run_op(input logic which, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat, input bit chk_ops,
                          input logic [67:0] e1, input logic [67:0] e2, input string tag);
        int lat;
        int cyc_acc;
        sel       = which;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b1;
        in_valid0 = !which;
        in_valid2 = which;
        #1;
        check_eq({tag, "_rdy_idle"}, 64'(s_in_ready), 64'd1);
        @(posedge clk);
        #1;
        cyc_acc   = cyc;
        in_valid0 = 1'b0;
        in_valid2 = 1'b0;
        lat       = 0;
        while (!s_out_valid && lat < 20) begin
            check_eq({tag, "_rdy_busy"}, 64'(s_in_ready), 64'd0);
            if (chk_ops && lat < 4) begin
                check_eq({tag, "_mul_en"}, 64'(s_mul_en), 64'd1);
                check_eq({tag, "_op1"}, 64'(s_op1), 64'(e1[lat*17 +: 17]));
                check_eq({tag, "_op2"}, 64'(s_op2), 64'(e2[lat*17 +: 17]));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_result"}, s_result, exp);
        check_eq({tag, "_rdy_done"}, 64'(s_in_ready), 64'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_span"}, 64'(cyc - cyc_acc), 64'(exp_lat + 1));
        check_eq({tag, "_valid_off"}, 64'(s_out_valid), 64'd0);
        check_eq({tag, "_rdy_back"}, 64'(s_in_ready), 64'd1);
        check_eq({tag, "_result_idle"}, s_result, exp);
    endtask

    initial begin
        logic [67:0] e1_v2;
        logic [67:0] e2_v2;
        int          wait_cnt;
        e1_v2 = {17'd1, 17'd2, 17'd1, 17'd2};
        e2_v2 = {17'd3, 17'd3, 17'd4, 17'd4};

        rst_n     = 1'b0;
        in_valid0 = 1'b0;
        in_valid2 = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        sel       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_eq("rst_in_ready", 64'(s_in_ready), 64'd1);
            check_eq("rst_out_valid", 64'(s_out_valid), 64'd0);
            check_eq("rst_result", s_result, 64'd0);
            check_eq("rst_mul_en", 64'(s_mul_en), 64'd0);
            check_eq("rst_ops", 64'({s_op1, s_op2}), 64'd0);
            check_eq("rst_busy", 64'(s_busy), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MUL_LAT=0 vectors
        run_op(1'b0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 4, 1'b0, '0, '0, "t1");
        run_op(1'b0, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 4, 1'b1,
               e1_v2, e2_v2, "t2");
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 4, 1'b0,
               '0, '0, "t3a");
        run_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 4, 1'b0,
               '0, '0, "t3b");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 4, 1'b0, '0, '0, "negneg");

        // Back-pressure: result must hold and new operands must be refused.
        sel       = 1'b0;
        in_a      = 32'd3;
        in_b      = 32'hFFFF_FFFB;
        out_ready = 1'b0;
        in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        wait_cnt  = 0;
        while (!out_valid0 && wait_cnt < 20) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        check_eq("t4_valid", 64'(out_valid0), 64'd1);
        in_a      = 32'h1234_5678;
        in_b      = 32'd2;
        in_valid0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("t4_hold_valid", 64'(out_valid0), 64'd1);
            check_eq("t4_hold_result", result0, 64'hFFFF_FFFF_FFFF_FFF1);
            check_eq("t4_hold_ready", 64'(in_ready0), 64'd0);
        end
        in_valid0 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t4_release_valid", 64'(out_valid0), 64'd0);
        check_eq("t4_release_busy", 64'(busy0), 64'd0);
        check_eq("t4_release_result", result0, 64'hFFFF_FFFF_FFFF_FFF1);

        // MUL_LAT=2 through the delayed multiplier, two operations back to back.
        run_op(1'b1, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 6, 1'b1,
               e1_v2, e2_v2, "t5a");
        run_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 6, 1'b0,
               '0, '0, "t5b");

        // Reset during issue slot 2 on the pipelined instance.
        sel       = 1'b1;
        in_a      = 32'h0001_0002;
        in_b      = 32'h0003_0004;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("t6_slot2_op1", 64'(op1_2), 64'd2);
        check_eq("t6_slot2_op2", 64'(op2_2), 64'd3);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_busy", 64'(busy2), 64'd0);
        check_eq("t6_rst_ready", 64'(in_ready2), 64'd1);
        check_eq("t6_rst_valid", 64'(out_valid2), 64'd0);
        check_eq("t6_rst_result", result2, 64'd0);
        check_eq("t6_rst_mul_en", 64'(mul_en2), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check_eq("t6_late_valid", 64'(out_valid2), 64'd0);
            check_eq("t6_late_result", result2, 64'd0);
        end
        run_op(1'b1, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 6, 1'b0,
               '0, '0, "t6_after");
        run_op(1'b0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 4, 1'b0, '0, '0,
               "t6_after0");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
